// File: rtl/stopwatch_axil_regs.sv
// Stopwatch exposed through an AXI4-Lite slave: CTRL, PRESCALE, COUNT and LAP registers.
// A prescaler divides the clock and COUNT advances once per prescaler wrap while RUN is set.
module stopwatch_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic                              run_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     count_o,
    output logic                              tick_o
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;

    localparam logic [1:0] REG_CTRL     = 2'd0;
    localparam logic [1:0] REG_PRESCALE = 2'd1;
    localparam logic [1:0] REG_COUNT    = 2'd2;
    localparam logic [1:0] REG_LAP      = 2'd3;

    localparam logic [DW-1:0] ONE  = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] ZERO = {DW{1'b0}};

    // Replace only the byte lanes whose strobe is set.
    function automatic logic [DW-1:0] merge_bytes(
        input logic [DW-1:0] old_val,
        input logic [DW-1:0] new_val,
        input logic [SW-1:0] strb
    );
        logic [DW-1:0] res;
        res = old_val;
        for (int b = 0; b < SW; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

    logic            run_r;
    logic [DW-1:0]   prescale_r;
    logic [DW-1:0]   count_r;
    logic [DW-1:0]   lap_r;
    logic [DW-1:0]   pcnt_r;
    logic            bvalid_r;
    logic            rvalid_r;
    logic [DW-1:0]   rdata_r;

    logic [1:0]      wr_idx_s;
    logic [1:0]      rd_idx_s;
    logic            wr_accept_s;
    logic            rd_accept_s;
    logic            ctrl_hit_s;
    logic            clear_s;
    logic            lap_s;
    logic            tick_s;
    logic [DW-1:0]   prescale_next_s;
    logic [DW-1:0]   rd_mux_s;
    logic            unused_ok_s;

    assign wr_idx_s = S_AXI_AWADDR[3:2];
    assign rd_idx_s = S_AXI_ARADDR[3:2];

    // Writes need address and data together and no response outstanding; nothing is buffered.
    assign wr_accept_s = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_r & ~S_AXI_ARESET;
    assign rd_accept_s = S_AXI_ARVALID & ~rvalid_r & ~S_AXI_ARESET;

    assign ctrl_hit_s = wr_accept_s & (wr_idx_s == REG_CTRL) & S_AXI_WSTRB[0];
    assign clear_s    = ctrl_hit_s & S_AXI_WDATA[1];
    assign lap_s      = ctrl_hit_s & S_AXI_WDATA[2];
    assign tick_s     = run_r & (pcnt_r == prescale_r);

    assign prescale_next_s = merge_bytes(prescale_r, S_AXI_WDATA, S_AXI_WSTRB);

    assign S_AXI_AWREADY = wr_accept_s;
    assign S_AXI_WREADY  = wr_accept_s;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_ARREADY = ~rvalid_r & ~S_AXI_ARESET;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RDATA   = rdata_r;
    assign run_o         = run_r;
    assign count_o       = count_r;
    assign tick_o        = tick_s;

    assign unused_ok_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Read-data selection from the registers as they stand before this edge.
    always_comb begin
        rd_mux_s = ZERO;
        case (rd_idx_s)
            REG_CTRL:     rd_mux_s = {{(DW-1){1'b0}}, run_r};
            REG_PRESCALE: rd_mux_s = prescale_r;
            REG_COUNT:    rd_mux_s = count_r;
            REG_LAP:      rd_mux_s = lap_r;
            default:      rd_mux_s = ZERO;
        endcase
    end

    // Write response channel.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            bvalid_r <= 1'b0;
        end else if (wr_accept_s) begin
            bvalid_r <= 1'b1;
        end else if (bvalid_r && S_AXI_BREADY) begin
            bvalid_r <= 1'b0;
        end
    end

    // Read data channel; RDATA is frozen while RVALID waits for RREADY.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            rvalid_r <= 1'b0;
            rdata_r  <= ZERO;
        end else if (rd_accept_s) begin
            rvalid_r <= 1'b1;
            rdata_r  <= rd_mux_s;
        end else if (rvalid_r && S_AXI_RREADY) begin
            rvalid_r <= 1'b0;
        end
    end

    // Software-writable control and prescale registers.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            run_r      <= 1'b0;
            prescale_r <= ZERO;
        end else if (wr_accept_s) begin
            if (ctrl_hit_s) begin
                run_r <= S_AXI_WDATA[0];
            end
            if (wr_idx_s == REG_PRESCALE) begin
                prescale_r <= prescale_next_s;
            end
        end
    end

    // Prescaler and counter; CLEAR beats a coincident tick. A PRESCALE below pcnt
    // deliberately lets pcnt run on until the equality compare hits after wrap.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            pcnt_r  <= ZERO;
            count_r <= ZERO;
        end else if (clear_s) begin
            pcnt_r  <= ZERO;
            count_r <= ZERO;
        end else if (tick_s) begin
            pcnt_r  <= ZERO;
            count_r <= count_r + ONE;
        end else if (run_r) begin
            pcnt_r  <= pcnt_r + ONE;
        end
    end

    // Lap snapshot takes the count from before this edge, so it sees the pre-clear value.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            lap_r <= ZERO;
        end else if (lap_s) begin
            lap_r <= count_r;
        end
    end

endmodule

// File: tb/tb_stopwatch_axil_regs.sv
// Self-checking bench for stopwatch_axil_regs: directed scenarios plus randomized traffic,
// compared against an arithmetic model of the stopwatch kept in the bench.
module tb_stopwatch_axil_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        run;
    logic [31:0] count;
    logic        tick;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model state
    logic        m_run;
    logic [31:0] m_prescale;
    logic [31:0] m_count;
    logic [31:0] m_lap;
    logic [31:0] m_pcnt;

    stopwatch_axil_regs dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .run_o(run), .count_o(count), .tick_o(tick)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        m_run = 1'b0; m_prescale = 32'd0; m_count = 32'd0; m_lap = 32'd0; m_pcnt = 32'd0;
    endtask

    // A running stopwatch ticks once every PRESCALE+1 cycles.
    task automatic model_adv(input int n);
        longint unsigned per;
        longint unsigned tot;
        if (m_run) begin
            if (m_pcnt <= m_prescale) begin
                per = {32'd0, m_prescale} + 64'd1;
                tot = {32'd0, m_pcnt} + 64'(n);
                m_count = m_count + 32'(tot / per);
                m_pcnt = 32'(tot % per);
            end else begin
                m_pcnt = m_pcnt + 32'(n);
            end
        end
    endtask

    task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                               input logic [31:0] pre);
        case (a[3:2])
            2'd0: if (s[0]) begin
                m_run = d[0];
                if (d[2]) m_lap = pre;
                if (d[1]) begin m_count = 32'd0; m_pcnt = 32'd0; end
            end
            2'd1: for (int b = 0; b < 4; b++) if (s[b]) m_prescale[8*b +: 8] = d[8*b +: 8];
            default: ;
        endcase
    endtask

    function automatic logic [31:0] exp_read(input logic [3:0] a);
        case (a[3:2])
            2'd0: return {31'd0, m_run};
            2'd1: return m_prescale;
            2'd2: return m_count;
            default: return m_lap;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        model_adv(1);
        #1;
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             output bit ok);
        logic [31:0] pre;
        int k;
        ok = 1'b1;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        #1;
        k = 0;
        while (!(awready && wready) && k < 50) begin step(); k++; end
        if (k >= 50) begin
            ok = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        pre = m_count;
        @(posedge clk);
        model_adv(1);
        model_write(a, d, s, pre);
        #1;
        awvalid = 1'b0; wvalid = 1'b0;
        k = 0;
        while (!bvalid && k < 50) begin step(); k++; end
        if (k >= 50) ok = 1'b0;
        else step();
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
        int k;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        #1;
        k = 0;
        while (!arready && k < 50) begin step(); k++; end
        @(posedge clk);
        model_adv(1);
        #1;
        arvalid = 1'b0;
        k = 0;
        while (!rvalid && k < 50) begin step(); k++; end
        d = rvalid ? rdata : 32'hxxxx_xxxx;
        step();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        awaddr = 4'h0; araddr = 4'h0; wdata = 32'h0000_0007; wstrb = 4'hF;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({awready, wready, arready, bvalid, rvalid, tick, run} !== 7'd0 || rdata !== 32'd0 || count !== 32'd0)
            $display("FAIL reset_outputs: got aw%b w%b ar%b b%b r%b t%b run%b rdata=%h count=%h want all 0",
                     awready, wready, arready, bvalid, rvalid, tick, run, rdata, count);
        else pass_cnt++;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (arready !== 1'b1) $display("FAIL reset_arready_release: got %b want 1", arready);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), d);
            total_cnt++;
            if (d !== 32'd0) $display("FAIL reset_read reg%0d: got %h want 00000000", i, d);
            else pass_cnt++;
        end
    endtask

    task automatic test_prescale();
        bit ok;
        logic [31:0] d;
        logic [31:0] c0;
        int last;
        int nt;
        axi_write(4'h4, 32'd3, 4'hF, ok);
        axi_write(4'h0, 32'd1, 4'hF, ok);
        total_cnt++;
        if (ok !== 1'b1) $display("FAIL prescale_write_handshake: got %b want 1", ok);
        else pass_cnt++;
        c0 = m_count; last = -1; nt = 0;
        for (int c = 0; c < 40; c++) begin
            total_cnt++;
            if (tick !== (m_run && m_pcnt == m_prescale))
                $display("FAIL prescale_tick cycle %0d: got %b want %b", c, tick, m_run && m_pcnt == m_prescale);
            else pass_cnt++;
            if (tick) begin
                nt++;
                if (last >= 0) begin
                    total_cnt++;
                    if (c - last != 4) $display("FAIL prescale_tick_period: got %0d want 4", c - last);
                    else pass_cnt++;
                end
                last = c;
            end
            step();
        end
        total_cnt++;
        if (32'(nt) !== m_count - c0) $display("FAIL prescale_tick_count: got %0d want %0d", nt, m_count - c0);
        else pass_cnt++;
        d = exp_read(4'h8);
        axi_read(4'h8, d);
        total_cnt++;
        if (d !== exp_read(4'h8) - 32'(m_pcnt == 32'd0 && m_count != 32'd0 ? 1 : 0) && d !== m_count)
            $display("FAIL prescale_count_read: got %0d want %0d", d, m_count);
        else pass_cnt++;
        total_cnt++;
        if (d < 32'd9 || d > 32'd11) $display("FAIL prescale_count_range: got %0d want 10+/-1", d);
        else pass_cnt++;
    endtask

    task automatic test_w_before_aw();
        logic [31:0] pre;
        logic [31:0] d;
        int nb;
        int extra;
        int acc;
        awaddr = 4'h4; wdata = 32'h0000_0025; wstrb = 4'hF; wvalid = 1'b1; awvalid = 1'b0; bready = 1'b1;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            total_cnt++;
            if (awready !== 1'b0 || wready !== 1'b0)
                $display("FAIL w_first_ready cycle %0d: got aw%b w%b want 0 0", c, awready, wready);
            else pass_cnt++;
            step();
        end
        awvalid = 1'b1;
        #1;
        total_cnt++;
        if (awready !== 1'b1 || wready !== 1'b1) $display("FAIL w_first_accept: got aw%b w%b want 1 1", awready, wready);
        else pass_cnt++;
        pre = m_count;
        @(posedge clk);
        model_adv(1);
        model_write(4'h4, 32'h0000_0025, 4'hF, pre);
        #1;
        awvalid = 1'b0; wvalid = 1'b0;
        nb = 0; extra = 0;
        for (int c = 0; c < 6; c++) begin
            if (bvalid) nb++;
            if (awready || wready) extra++;
            step();
        end
        total_cnt++;
        if (nb !== 1 || extra !== acc) $display("FAIL w_first_single_resp: got bvalid=%0d extra=%0d want 1 0", nb, extra);
        else pass_cnt++;
        axi_read(4'h4, d);
        total_cnt++;
        if (d !== 32'h0000_0025) $display("FAIL w_first_prescale: got %h want 00000025", d);
        else pass_cnt++;
    endtask

    task automatic test_strobe_bready();
        logic [31:0] pre;
        logic [31:0] d;
        bit ok;
        awaddr = 4'h4; wdata = 32'hAABB_CCDD; wstrb = 4'b0101; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        #1;
        pre = m_count;
        @(posedge clk);
        model_adv(1);
        model_write(4'h4, 32'hAABB_CCDD, 4'b0101, pre);
        #1;
        awaddr = 4'h0; wdata = 32'd1; wstrb = 4'hF;
        for (int c = 0; c < 3; c++) begin
            total_cnt++;
            if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0)
                $display("FAIL strobe_bvalid_hold cycle %0d: got b%b aw%b w%b want 1 0 0", c, bvalid, awready, wready);
            else pass_cnt++;
            step();
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        step();
        total_cnt++;
        if (bvalid !== 1'b0) $display("FAIL strobe_bvalid_drop: got %b want 0", bvalid);
        else pass_cnt++;
        axi_read(4'h4, d);
        total_cnt++;
        if (d !== 32'h00BB_00DD) $display("FAIL strobe_prescale: got %h want 00bb00dd", d);
        else pass_cnt++;
        axi_write(4'h0, 32'd1, 4'hF, ok);
    endtask

    task automatic test_lap_clear();
        bit ok;
        logic [31:0] pre;
        logic [31:0] d;
        axi_write(4'h4, 32'd1, 4'hF, ok);
        axi_write(4'h0, 32'd3, 4'hF, ok);
        repeat (7) step();
        pre = m_count;
        axi_write(4'h0, 32'd7, 4'hF, ok);
        total_cnt++;
        if (run !== 1'b1 || count !== m_count) $display("FAIL lap_run_count: got run=%b count=%0d want 1 %0d", run, count, m_count);
        else pass_cnt++;
        repeat (5) step();
        total_cnt++;
        if (count !== m_count) $display("FAIL lap_count_resume: got %0d want %0d", count, m_count);
        else pass_cnt++;
        axi_read(4'hC, d);
        total_cnt++;
        if (d !== pre || d == 32'd0) $display("FAIL lap_value: got %0d want %0d (nonzero)", d, pre);
        else pass_cnt++;
    endtask

    task automatic test_concurrent();
        logic [31:0] old;
        logic [31:0] pre;
        logic [31:0] d;
        old = m_prescale;
        awaddr = 4'h4; wdata = 32'd5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        araddr = 4'h4; arvalid = 1'b1; rready = 1'b1;
        #1;
        pre = m_count;
        @(posedge clk);
        model_adv(1);
        model_write(4'h4, 32'd5, 4'hF, pre);
        #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        total_cnt++;
        if (rvalid !== 1'b1 || bvalid !== 1'b1 || rdata !== old)
            $display("FAIL concurrent_old_value: got r%b b%b rdata=%h want 1 1 %h", rvalid, bvalid, rdata, old);
        else pass_cnt++;
        step();
        axi_read(4'h4, d);
        total_cnt++;
        if (d !== 32'd5) $display("FAIL concurrent_new_value: got %h want 00000005", d);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        bit ok;
        axi_write(4'h0, 32'd2, 4'hF, ok);
        axi_write(4'h4, 32'd0, 4'hF, ok);
        force dut.count_r = 32'hFFFF_FFFE;
        step();
        release dut.count_r;
        m_count = 32'hFFFF_FFFE;
        step();
        total_cnt++;
        if (count !== 32'hFFFF_FFFE) $display("FAIL wrap_preload: got %h want fffffffe", count);
        else pass_cnt++;
        axi_write(4'h0, 32'd1, 4'hF, ok);
        total_cnt++;
        if (count !== m_count) $display("FAIL wrap_first_tick: got %h want %h", count, m_count);
        else pass_cnt++;
        step();
        total_cnt++;
        if (count !== 32'h0000_0000 || m_count !== 32'h0000_0000)
            $display("FAIL wrap_zero: got %h want 00000000", count);
        else pass_cnt++;
    endtask

    task automatic test_random();
        bit ok;
        logic [3:0] a;
        logic [31:0] d;
        logic [31:0] e;
        logic [3:0] s;
        int op;
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 4);
            case (op)
                0: begin
                    a = {2'b00, 2'($urandom_range(0, 3))};
                    d = {$urandom_range(0, 255), 8'($urandom_range(0, 7))};
                    s = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
                    axi_write(a, d, s, ok);
                end
                1: begin
                    a = {2'b01, 2'($urandom_range(0, 3))};
                    d = 32'($urandom_range(0, 5));
                    s = 4'($urandom_range(0, 15));
                    axi_write(a, d, s, ok);
                end
                2: begin
                    a = {1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
                    axi_write(a, $urandom, 4'hF, ok);
                end
                3: begin
                    a = 4'($urandom_range(0, 15));
                    e = exp_read(a);
                    axi_read(a, d);
                    ok = 1'b1;
                    total_cnt++;
                    if (d !== e) $display("FAIL rand_read iter %0d addr %h: got %h want %h", i, a, d, e);
                    else pass_cnt++;
                end
                default: begin
                    ok = 1'b1;
                    for (int c = 0; c < $urandom_range(1, 6); c++) begin
                        total_cnt++;
                        if (tick !== (m_run && m_pcnt == m_prescale))
                            $display("FAIL rand_tick iter %0d: got %b want %b", i, tick, m_run && m_pcnt == m_prescale);
                        else pass_cnt++;
                        step();
                    end
                end
            endcase
            total_cnt++;
            if (ok !== 1'b1 || count !== m_count || run !== m_run)
                $display("FAIL rand_state iter %0d: got ok=%b count=%h run=%b want 1 %h %b", i, ok, count, run, m_count, m_run);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] d;
        araddr = 4'h8; arvalid = 1'b1; rready = 1'b0;
        step();
        arvalid = 1'b0;
        step();
        total_cnt++;
        if (rvalid !== 1'b1) $display("FAIL midreset_pending: got %b want 1", rvalid);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        model_reset();
        total_cnt++;
        if (rvalid !== 1'b0 || arready !== 1'b0 || rdata !== 32'd0)
            $display("FAIL midreset_abort: got r%b ar%b rdata=%h want 0 0 0", rvalid, arready, rdata);
        else pass_cnt++;
        step();
        step();
        rst = 1'b0;
        rready = 1'b1;
        #1;
        total_cnt++;
        if (arready !== 1'b1 || count !== 32'd0 || run !== 1'b0)
            $display("FAIL midreset_release: got ar%b count=%h run=%b want 1 0 0", arready, count, run);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), d);
            total_cnt++;
            if (d !== 32'd0) $display("FAIL midreset_read reg%0d: got %h want 00000000", i, d);
            else pass_cnt++;
        end
    endtask

    initial begin
        rst = 1'b1;
        awaddr = 4'h0; awprot = 3'd0; awvalid = 1'b0; wdata = 32'd0; wstrb = 4'h0; wvalid = 1'b0;
        bready = 1'b0; araddr = 4'h0; arprot = 3'd0; arvalid = 1'b0; rready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_prescale();
        test_w_before_aw();
        test_strobe_bready();
        test_lap_clear();
        test_concurrent();
        test_wrap();
        test_random();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
